// File: rtl/soc_system_sysinfo_qsys.sv
// soc_system_sysinfo_qsys
// System-information slave for the Avalon-MM control fabric. It returns
// build-time identity words and a capability word. It also provides:
//   - a 64-bit free-running cycle counter, with an atomic snapshot of the
//     high word taken whenever the low word is read
//   - a seconds counter, prescaled from the clock frequency
//   - a bank of byte-writable scratch registers
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   address        word address (ADDR_W bits)
//   read / write   single-cycle transfer strobes; read wins when both are set
//   writedata      32-bit write data
//   byteenable     write byte lanes
//   readdata       registered read data; holds its value between pulses
//   readdatavalid  one-cycle pulse qualifying readdata
//
// Read timing: a read sampled at edge N captures its value at N, and the
// value is presented with readdatavalid after edge N+1. Because the request
// is still in flight for one extra cycle, a reset in that cycle drops it.

module soc_system_sysinfo_qsys #(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter logic [7:0]  VERSION     = 8'd2,
    parameter logic [31:0] CLK_FREQ_HZ = 32'd50_000_000,
    parameter int          NUM_SCRATCH = 4,
    parameter int          ADDR_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int SCR_BASE = 6;

    if (NUM_SCRATCH < 1 || NUM_SCRATCH > 16) begin : g_bad_num_scratch
        $fatal(1, "NUM_SCRATCH must be in 1..16");
    end
    if ((2 ** ADDR_W) < (SCR_BASE + NUM_SCRATCH)) begin : g_bad_addr_w
        $fatal(1, "ADDR_W too small for the register map");
    end
    if (CLK_FREQ_HZ == 32'd0) begin : g_bad_clk_freq
        $fatal(1, "CLK_FREQ_HZ must be at least 1");
    end

    localparam logic [ADDR_W-1:0] A_SYSID = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TSTMP = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CAPS  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_UP_LO = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UP_HI = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_SECS  = ADDR_W'(5);

    localparam logic [31:0] CAPS_WORD   = {8'h00, 8'(NUM_SCRATCH), 8'(SCR_BASE), VERSION};
    localparam logic [31:0] PRESCALE_TC = CLK_FREQ_HZ - 32'd1;

    logic [63:0] cycle_cnt;
    logic [31:0] prescale;     // down-counter: reload value PRESCALE_TC, wraps at 0
    logic [31:0] seconds;
    logic [31:0] shadow_hi;
    logic [31:0] scratch [NUM_SCRATCH];

    logic [31:0] rd_mux;
    logic [31:0] rd_data_q;
    logic        rd_pend;
    logic        wr_en;
    logic        clr;

    // A simultaneous read discards the write entirely.
    assign wr_en = write & ~read;
    assign clr   = wr_en & (address == A_UP_LO) & byteenable[0] & writedata[0];

    always_comb begin
        rd_mux = 32'h0;
        case (address)
            A_SYSID: rd_mux = SYSTEM_ID;
            A_TSTMP: rd_mux = TIMESTAMP;
            A_CAPS:  rd_mux = CAPS_WORD;
            A_UP_LO: rd_mux = cycle_cnt[31:0];
            A_UP_HI: rd_mux = shadow_hi;
            A_SECS:  rd_mux = seconds;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == ADDR_W'(SCR_BASE + i)) begin
                        rd_mux = scratch[i];
                    end
                end
            end
        endcase
    end

    // Cycle, prescaler and seconds counters. The prescaler counts down from
    // CLK_FREQ_HZ-1, so reaching zero is the cycle in which a second elapses.
    // A clear always overrides a wrap in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt <= 64'h0;
            prescale  <= PRESCALE_TC;
            seconds   <= 32'h0;
        end else if (clr) begin
            cycle_cnt <= 64'h0;
            prescale  <= PRESCALE_TC;
            seconds   <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (prescale == 32'h0) begin
                prescale <= PRESCALE_TC;
                seconds  <= seconds + 32'd1;
            end else begin
                prescale <= prescale - 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= 32'h0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (address == ADDR_W'(SCR_BASE + i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read pipeline. The snapshot of the high word is taken on the same edge
    // that samples the low word, so a LO-then-HI pair is always coherent.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_hi     <= 32'h0;
            rd_data_q     <= 32'h0;
            rd_pend       <= 1'b0;
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            rd_pend       <= read;
            readdatavalid <= rd_pend;
            if (read) begin
                rd_data_q <= rd_mux;
                if (address == A_UP_LO) begin
                    shadow_hi <= cycle_cnt[63:32];
                end
            end
            if (rd_pend) begin
                readdata <= rd_data_q;
            end
        end
    end

endmodule

// File: tb/tb_soc_system_sysinfo_qsys.sv
module tb_soc_system_sysinfo_qsys;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'h0;
    logic [3:0]    byteenable = 4'h0;
    logic [31:0]   readdata;
    logic          readdatavalid;

    soc_system_sysinfo_qsys #(
        .SYSTEM_ID   (32'h5900_A01F),
        .TIMESTAMP   (32'h6500_0000),
        .CLK_FREQ_HZ (32'd10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int r0       = 0;

    logic [31:0] q_data [$];
    int          q_due  [$];
    int          q_addr [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest pending read,
    // both in data and in the cycle it was due.
    always @(negedge clock) begin
        if (readdatavalid) begin
            if (q_data.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: readdata=%h, expected no pulse", readdata);
            end else begin
                logic [31:0] e;
                int          due;
                int          a;
                e   = q_data.pop_front();
                due = q_due.pop_front();
                a   = q_addr.pop_front();
                n_checks++;
                if (readdata !== e) begin
                    n_fail++;
                    $display("FAIL rd_data_a%0d: got %h, expected %h", a, readdata, e);
                end
                n_checks++;
                if (cyc != due) begin
                    n_fail++;
                    $display("FAIL rd_latency_a%0d: got cycle %0d, expected cycle %0d", a, cyc, due);
                end
            end
        end
    end

    task automatic do_read(input int a, input logic [31:0] d);
        q_data.push_back(d);
        q_due.push_back(cyc + 2);
        q_addr.push_back(a);
        address = AW'(a);
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        address    = AW'(a);
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(negedge clock);
        write      = 1'b0;
    endtask

    task automatic do_read_write(input int a, input logic [31:0] d, input logic [31:0] exp);
        q_data.push_back(exp);
        q_due.push_back(cyc + 2);
        q_addr.push_back(a);
        address    = AW'(a);
        writedata  = d;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        @(negedge clock);
        read       = 1'b0;
        write      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_valid", {31'b0, readdatavalid}, 32'h0);
        reset = 1'b0;
        r0    = cyc;
    endtask

    task automatic drain();
        repeat (3) @(negedge clock);
        chk("pending_reads", q_data.size(), 32'h0);
    endtask

    initial begin
        #200_000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Seconds counter with a 10-cycle prescaler.
        do_reset();
        repeat (24) @(negedge clock);
        do_read(5, 32'd2);                       // sampled 25 cycles after release
        repeat (4) @(negedge clock);
        do_write(3, 32'h1, 4'b0001);             // clear on the prescaler wrap edge
        do_read(3, 32'h0);
        do_read(3, 32'h1);
        do_read(5, 32'h0);
        repeat (6) @(negedge clock);
        do_read(5, 32'h0);                       // 10th cycle after clear, before increment
        do_read(5, 32'h1);
        drain();

        // Identity words, back to back.
        do_reset();
        do_read(0, 32'h5900_A01F);
        do_read(1, 32'h6500_0000);
        do_read(2, 32'h0004_0602);
        do_read(4, 32'h0);
        do_read(9, 32'h0);

        // Scratch byte lanes and unmapped / read-only addresses.
        do_write(6, 32'hDEAD_BEEF, 4'b0101);
        do_read(6, 32'h00AD_00EF);
        do_write(6, 32'h1234_5678, 4'b1111);
        do_read(6, 32'h1234_5678);
        do_write(9, 32'hCAFE_F00D, 4'b1100);
        do_read(9, 32'hCAFE_0000);
        do_read(10, 32'h0);
        do_read(15, 32'h0);
        do_write(0, 32'hFFFF_FFFF, 4'b1111);
        do_read(0, 32'h5900_A01F);
        do_write(10, 32'hFFFF_FFFF, 4'b1111);
        do_read(10, 32'h0);

        // A LO write without byteenable[0] must not clear the counter.
        do_write(3, 32'hFFFF_FFFF, 4'b1110);
        do_read(3, 32'(cyc - r0));

        // Read and write together: read wins, write discarded.
        do_write(7, 32'hA5A5_0F0F, 4'b1111);
        do_read_write(7, 32'hFFFF_FFFF, 32'hA5A5_0F0F);
        do_read(7, 32'hA5A5_0F0F);
        drain();

        // 64-bit snapshot across the 2^32 boundary.
        dut.cycle_cnt = 64'h0000_0000_FFFF_FFF0;
        do_read(3, 32'hFFFF_FFF0);
        repeat (32) @(negedge clock);
        do_read(4, 32'h0);
        do_read(3, 32'h0000_0012);
        do_read(4, 32'h1);
        drain();

        // Reset in the cycle after a read drops that read.
        address = AW'(0);
        read    = 1'b1;
        @(negedge clock);
        read    = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        chk("rst_drop_valid", {31'b0, readdatavalid}, 32'h0);
        chk("rst_drop_data", readdata, 32'h0);
        @(negedge clock);
        chk("rst_drop_valid_late", {31'b0, readdatavalid}, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
